pipe_stage_skid: RTL

Parametrised pipeline-stage register with valid/ready handshake, stall-by-backpressure, flush-to-bubble and an optional 2-entry skid buffer. It is the generic successor to the fixed-field ID/EX register. Stages are now instantiated per boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with the payload packed into a data field and a control field. Unlike the old register, a stall holds contents instead of zeroing them, and only control bits are cleared on flush.

---
 rtl/pipe_stage_skid.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, flush-to-bubble and an optional 2-entry skid buffer.
// Latency 1 cycle; SKID=1 gives a registered in_ready, SKID=0 passes out_ready through combinationally.
module pipe_stage_skid #(
   parameter int unsigned DATA_W              = 128,
   parameter int unsigned CTRL_W              = 16,
   parameter bit          SKID                = 1'b1,
   parameter bit          CLEAR_DATA_ON_FLUSH = 1'b0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [1:0]        occupancy_o
);

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
   logic              rdy_q,     rdy_d;
   logic              in_fire;
   logic              out_fire;

   // rdy_q is low through reset so in_ready only rises on the first edge after release.
   assign in_ready_o  = SKID ? rdy_q : (rdy_q & (~m_valid_q | out_ready_i));
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = m_valid_q & out_ready_i;
   assign out_valid_o = m_valid_q;
   assign out_data_o  = m_data_q;
   assign out_ctrl_o  = m_ctrl_q & {CTRL_W{m_valid_q}};
   assign occupancy_o = {1'b0, m_valid_q} + {1'b0, s_valid_q};

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ctrl_d  = m_ctrl_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_ctrl_d  = s_ctrl_q;
      if (flush_i) begin
         m_valid_d = 1'b0;
         m_ctrl_d  = '0;
         s_valid_d = 1'b0;
         s_ctrl_d  = '0;
         if (CLEAR_DATA_ON_FLUSH) begin
            m_data_d = '0;
            s_data_d = '0;
         end
      end else if (SKID) begin
         if (s_valid_q) begin
            // Skid full implies main full; in_ready is low so no input can arrive.
            if (out_ready_i) begin
               m_data_d  = s_data_q;
               m_ctrl_d  = s_ctrl_q;
               s_valid_d = 1'b0;
            end
         end else if (in_fire) begin
            if (!m_valid_q || out_ready_i) begin
               m_valid_d = 1'b1;
               m_data_d  = in_data_i;
               m_ctrl_d  = in_ctrl_i;
            end else begin
               s_valid_d = 1'b1;
               s_data_d  = in_data_i;
               s_ctrl_d  = in_ctrl_i;
            end
         end else if (out_fire) begin
            m_valid_d = 1'b0;
         end
      end else begin
         if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data_i;
            m_ctrl_d  = in_ctrl_i;
         end else if (out_fire) begin
            m_valid_d = 1'b0;
         end
      end
      rdy_d = SKID ? ~s_valid_d : 1'b1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ctrl_q  <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_ctrl_q  <= '0;
         rdy_q     <= 1'b0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_ctrl_q  <= m_ctrl_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_ctrl_q  <= s_ctrl_d;
         rdy_q     <= rdy_d;
      end
   end

endmodule
